// File: rtl/qos_interconnect_n.sv
// Parametrised QOS interconnect: Main FIFO -> N_VC virtual-channel FIFOs -> arbiter -> N_DEST destination FIFOs.
// Optional macro QOS_INTC_RR_ARB_EN selects a round-robin arbiter instead of strict priority (lowest VC wins).
module qos_interconnect_n #(
    parameter int BW         = 6,
    parameter int N_VC       = 2,
    parameter int N_DEST     = 2,
    parameter int MAIN_DEPTH = 4,
    parameter int VC_DEPTH   = 16,
    parameter int D_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 Main_wr,
    input  logic [BW-1:0]        Main_data_in,
    output logic                 Main_full,
    output logic                 Main_empty,
    output logic                 Main_error_output,
    output logic [N_VC-1:0]      VC_empty,
    input  logic [N_DEST-1:0]    D_rd,
    output logic [N_DEST*BW-1:0] D_data_out,
    output logic [N_DEST-1:0]    D_empty,
    output logic [N_DEST-1:0]    D_full,
    output logic [N_DEST-1:0]    D_error_output
);

    localparam int VC_W = $clog2(N_VC);
    localparam int D_W  = $clog2(N_DEST);
    localparam int MA_W = $clog2(MAIN_DEPTH);
    localparam int VA_W = $clog2(VC_DEPTH);
    localparam int DA_W = $clog2(D_DEPTH);

    localparam logic [MA_W:0] MAIN_FULL_CNT = (MA_W+1)'(MAIN_DEPTH);
    localparam logic [VA_W:0] VC_FULL_CNT   = (VA_W+1)'(VC_DEPTH);
    localparam logic [DA_W:0] D_FULL_CNT    = (DA_W+1)'(D_DEPTH);

    function automatic logic [N_VC-1:0] f_lowest(input logic [N_VC-1:0] v);
        return v & (~v + N_VC'(1));
    endfunction

    function automatic logic [VC_W-1:0] f_oh2idx(input logic [N_VC-1:0] oh);
        logic [VC_W-1:0] idx;
        idx = {VC_W{1'b0}};
        for (int k = 0; k < N_VC; k++) begin
            idx = idx | (VC_W'(k) & {VC_W{oh[k]}});
        end
        return idx;
    endfunction

    logic [BW-1:0]   r_main_mem [MAIN_DEPTH];
    logic [MA_W-1:0] r_main_wptr;
    logic [MA_W-1:0] r_main_rptr;
    logic [MA_W:0]   r_main_cnt;
    logic            r_main_err;
    logic            w_main_push;
    logic            w_main_pop;
    logic [BW-1:0]   w_main_head;
    logic [VC_W-1:0] w_main_vc;

    logic [N_VC-1:0]           w_vc_full;
    logic [N_VC-1:0]           w_vc_elig;
    logic [N_VC-1:0][BW-1:0]   w_vc_head;
    logic [N_VC-1:0][D_W-1:0]  w_vc_dest;

    logic            w_grant_vld;
    logic [VC_W-1:0] w_grant_idx;
    logic [D_W-1:0]  w_grant_dest;
    logic [BW-1:0]   w_grant_word;

    assign Main_full         = (r_main_cnt == MAIN_FULL_CNT);
    assign Main_empty        = (r_main_cnt == (MA_W+1)'(0));
    assign Main_error_output = r_main_err;
    assign w_main_push       = Main_wr & ~Main_full;
    assign w_main_head       = r_main_mem[r_main_rptr];
    assign w_main_vc         = w_main_head[BW-1 -: VC_W];
    // Head-of-line: Main pops only when its head's VC has room.
    assign w_main_pop        = ~Main_empty & ~w_vc_full[w_main_vc];

    // Main FIFO pointers, occupancy and overflow flag
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_main_wptr <= {MA_W{1'b0}};
            r_main_rptr <= {MA_W{1'b0}};
            r_main_cnt  <= {(MA_W+1){1'b0}};
            r_main_err  <= 1'b0;
        end else begin
            r_main_err <= Main_wr & Main_full;
            if (w_main_push) begin
                r_main_wptr <= r_main_wptr + MA_W'(1);
            end
            if (w_main_pop) begin
                r_main_rptr <= r_main_rptr + MA_W'(1);
            end
            case ({w_main_push, w_main_pop})
                2'b10:   r_main_cnt <= r_main_cnt + (MA_W+1)'(1);
                2'b01:   r_main_cnt <= r_main_cnt - (MA_W+1)'(1);
                default: r_main_cnt <= r_main_cnt;
            endcase
        end
    end

    // Main FIFO storage
    always_ff @(posedge clk) begin
        if (w_main_push) begin
            r_main_mem[r_main_wptr] <= Main_data_in;
        end
    end

    for (genvar g = 0; g < N_VC; g++) begin : g_vc
        logic [BW-1:0]   r_mem [VC_DEPTH];
        logic [VA_W-1:0] r_wptr;
        logic [VA_W-1:0] r_rptr;
        logic [VA_W:0]   r_cnt;
        logic            w_push;
        logic            w_pop;

        assign w_push       = w_main_pop & (w_main_vc == VC_W'(g));
        assign w_pop        = w_grant_vld & (w_grant_idx == VC_W'(g));
        assign VC_empty[g]  = (r_cnt == (VA_W+1)'(0));
        assign w_vc_full[g] = (r_cnt == VC_FULL_CNT);
        assign w_vc_head[g] = r_mem[r_rptr];
        assign w_vc_dest[g] = w_vc_head[g][BW-1-VC_W -: D_W];
        assign w_vc_elig[g] = ~VC_empty[g] & ~D_full[w_vc_dest[g]];

        // VC FIFO pointers and occupancy
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                r_wptr <= {VA_W{1'b0}};
                r_rptr <= {VA_W{1'b0}};
                r_cnt  <= {(VA_W+1){1'b0}};
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + VA_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + VA_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + (VA_W+1)'(1);
                    2'b01:   r_cnt <= r_cnt - (VA_W+1)'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // VC FIFO storage
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= w_main_head;
            end
        end
    end

    assign w_grant_vld = |w_vc_elig;

`ifdef QOS_INTC_RR_ARB_EN
    logic [VC_W-1:0] r_last_grant;
    logic [VC_W-1:0] w_rr_base;
    logic [N_VC-1:0] w_elig_rot;

    // Rotate so the search starts one past the last grant, then undo the rotation.
    assign w_rr_base   = r_last_grant + VC_W'(1);
    assign w_elig_rot  = N_VC'({w_vc_elig, w_vc_elig} >> w_rr_base);
    assign w_grant_idx = f_oh2idx(f_lowest(w_elig_rot)) + w_rr_base;

    // Round-robin pointer, moves only on a grant
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_last_grant <= VC_W'(N_VC - 1);
        end else if (w_grant_vld) begin
            r_last_grant <= w_grant_idx;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end
`else
    assign w_grant_idx = f_oh2idx(f_lowest(w_vc_elig));
`endif

    assign w_grant_dest = w_vc_dest[w_grant_idx];
    assign w_grant_word = w_vc_head[w_grant_idx];

    for (genvar g = 0; g < N_DEST; g++) begin : g_dst
        logic [BW-1:0]   r_mem [D_DEPTH];
        logic [DA_W-1:0] r_wptr;
        logic [DA_W-1:0] r_rptr;
        logic [DA_W:0]   r_cnt;
        logic            r_err;
        logic            w_push;
        logic            w_pop;

        assign w_push            = w_grant_vld & (w_grant_dest == D_W'(g));
        assign w_pop             = D_rd[g] & ~D_empty[g];
        assign D_empty[g]        = (r_cnt == (DA_W+1)'(0));
        assign D_full[g]         = (r_cnt == D_FULL_CNT);
        assign D_error_output[g] = r_err;
        assign D_data_out[g*BW +: BW] = D_empty[g] ? BW'(0) : r_mem[r_rptr];

        // Destination FIFO pointers, occupancy and underflow flag
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                r_wptr <= {DA_W{1'b0}};
                r_rptr <= {DA_W{1'b0}};
                r_cnt  <= {(DA_W+1){1'b0}};
                r_err  <= 1'b0;
            end else begin
                r_err <= D_rd[g] & D_empty[g];
                if (w_push) begin
                    r_wptr <= r_wptr + DA_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + DA_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + (DA_W+1)'(1);
                    2'b01:   r_cnt <= r_cnt - (DA_W+1)'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Destination FIFO storage
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr] <= w_grant_word;
            end
        end
    end

endmodule

// File: tb/tb_qos_interconnect_n.sv
// Directed bench for qos_interconnect_n at default parameters; covers both arbiter builds.
module tb_qos_interconnect_n;

    logic        clk;
    logic        reset_L;
    logic        Main_wr;
    logic [5:0]  Main_data_in;
    logic        Main_full;
    logic        Main_empty;
    logic        Main_error_output;
    logic [1:0]  VC_empty;
    logic [1:0]  D_rd;
    logic [11:0] D_data_out;
    logic [1:0]  D_empty;
    logic [1:0]  D_full;
    logic [1:0]  D_error_output;

    int n_vec = 0;
    int n_err = 0;

    qos_interconnect_n dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .Main_wr           (Main_wr),
        .Main_data_in      (Main_data_in),
        .Main_full         (Main_full),
        .Main_empty        (Main_empty),
        .Main_error_output (Main_error_output),
        .VC_empty          (VC_empty),
        .D_rd              (D_rd),
        .D_data_out        (D_data_out),
        .D_empty           (D_empty),
        .D_full            (D_full),
        .D_error_output    (D_error_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [5:0]  din;
        logic [1:0]  rd;
        logic        me;
        logic [1:0]  vce;
        logic [1:0]  de;
        logic [1:0]  df;
        logic [1:0]  derr;
        logic        merr;
        logic [11:0] dout;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] exp_q [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_L = 1'b0;
        #2;
        reset_L = 1'b1;
    endtask

    initial begin
        int w;
        reset_L      = 1'b0;
        Main_wr      = 1'b0;
        Main_data_in = 6'h00;
        D_rd         = 2'b00;

        // fields: wr, din, rd | Main_empty, VC_empty, D_empty, D_full, D_err, Main_err, D_data_out
        tbl.push_back('{1'b1, 6'h2A, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b0, 6'h00, 2'b00, 1'b1, 2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b0, 6'h00, 2'b00, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 12'h02A});
        tbl.push_back('{1'b0, 6'h00, 2'b10, 1'b1, 2'b11, 2'b10, 2'b00, 2'b10, 1'b0, 12'h02A});
        tbl.push_back('{1'b0, 6'h00, 2'b00, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 12'h02A});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h01, 2'b00, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h02, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h03, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h04, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h05, 2'b00, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h06, 2'b00, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b1, 6'h07, 2'b00, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b0, 6'h00, 2'b00, 1'b1, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 12'h001});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 12'h002});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 12'h003});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 12'h004});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 12'h005});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 12'h006});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 12'h007});
        tbl.push_back('{1'b0, 6'h00, 2'b01, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 12'h000});
        tbl.push_back('{1'b0, 6'h00, 2'b00, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 12'h000});

`ifdef QOS_INTC_RR_ARB_EN
        exp_q = '{6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23};
`else
        exp_q = '{6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h01, 6'h02, 6'h03, 6'h21, 6'h22, 6'h23};
`endif

        #2;
        chk("rst_main_empty", 32'(Main_empty), 32'(1));
        chk("rst_main_full",  32'(Main_full), 32'(0));
        chk("rst_vc_empty",   32'(VC_empty), 32'(2'b11));
        chk("rst_d_empty",    32'(D_empty), 32'(2'b11));
        chk("rst_d_full",     32'(D_full), 32'(2'b00));
        chk("rst_d_dout",     32'(D_data_out), 32'(0));
        chk("rst_errs",       32'({Main_error_output, D_error_output}), 32'(0));
        @(negedge clk);
        reset_L = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            Main_wr      = tbl[i].wr;
            Main_data_in = tbl[i].din;
            D_rd         = tbl[i].rd;
            step();
            chk($sformatf("v%0d_main_empty", i), 32'(Main_empty), 32'(tbl[i].me));
            chk($sformatf("v%0d_main_full", i),  32'(Main_full), 32'(0));
            chk($sformatf("v%0d_vc_empty", i),   32'(VC_empty), 32'(tbl[i].vce));
            chk($sformatf("v%0d_d_empty", i),    32'(D_empty), 32'(tbl[i].de));
            chk($sformatf("v%0d_d_full", i),     32'(D_full), 32'(tbl[i].df));
            chk($sformatf("v%0d_d_err", i),      32'(D_error_output), 32'(tbl[i].derr));
            chk($sformatf("v%0d_main_err", i),   32'(Main_error_output), 32'(tbl[i].merr));
            chk($sformatf("v%0d_dout", i),       32'(D_data_out), 32'(tbl[i].dout));
        end
        Main_wr = 1'b0;
        D_rd    = 2'b00;

        // D0 full with VC0 blocked behind it; a dest1 word must still pass
        for (int k = 1; k <= 5; k++) begin
            Main_wr      = 1'b1;
            Main_data_in = 6'(k);
            step();
        end
        Main_wr = 1'b0;
        repeat (3) step();
        Main_wr      = 1'b1;
        Main_data_in = 6'h30;
        step();
        Main_wr = 1'b0;
        repeat (4) step();
        chk("blk_d_empty",  32'(D_empty), 32'(2'b00));
        chk("blk_d_full",   32'(D_full), 32'(2'b01));
        chk("blk_dout",     32'(D_data_out), 32'(12'hC01));
        chk("blk_vc_empty", 32'(VC_empty), 32'(2'b10));

        // Arbitration order: D0 prefilled by VC1, then both VCs loaded
        pulse_reset();
        step();
        for (int k = 0; k < 4; k++) begin
            Main_wr      = 1'b1;
            Main_data_in = exp_q[k];
            step();
        end
        Main_wr = 1'b0;
        repeat (6) step();
        Main_wr = 1'b1;
        Main_data_in = 6'h01; step();
        Main_data_in = 6'h02; step();
        Main_data_in = 6'h03; step();
        Main_data_in = 6'h21; step();
        Main_data_in = 6'h22; step();
        Main_data_in = 6'h23; step();
        Main_wr = 1'b0;
        repeat (8) step();
        chk("arb_pre_d_full",   32'(D_full), 32'(2'b01));
        chk("arb_pre_vc_empty", 32'(VC_empty), 32'(2'b00));
        chk("arb_pre_main",     32'(Main_empty), 32'(1));
        for (int i = 0; i < 10; i++) begin
            w = 0;
            while (D_empty[0] && w < 20) begin
                step();
                w++;
            end
            chk($sformatf("arb_avail%0d", i), 32'(D_empty[0]), 32'(0));
            chk($sformatf("arb_word%0d", i), 32'(D_data_out[5:0]), 32'(exp_q[i]));
            D_rd = 2'b01;
            step();
            D_rd = 2'b00;
            chk($sformatf("arb_rd_err%0d", i), 32'(D_error_output), 32'(0));
        end
        step();
        chk("arb_post_d_empty",  32'(D_empty), 32'(2'b11));
        chk("arb_post_vc_empty", 32'(VC_empty), 32'(2'b11));

        // Back-pressure all the way to Main, then overflow it
        pulse_reset();
        step();
        Main_wr = 1'b1;
        for (int k = 0; k < 30; k++) begin
            Main_data_in = 6'(k & 15);
            step();
        end
        chk("fill_main_full", 32'(Main_full), 32'(1));
        chk("fill_main_err",  32'(Main_error_output), 32'(1));
        chk("fill_d_full",    32'(D_full), 32'(2'b01));
        chk("fill_vc0",       32'(VC_empty[0]), 32'(0));
        Main_wr = 1'b0;
        step();
        chk("fill_err_clear", 32'(Main_error_output), 32'(0));

        // Asynchronous reset with every stage holding words
        reset_L = 1'b0;
        #1;
        chk("mid_main_empty", 32'(Main_empty), 32'(1));
        chk("mid_main_full",  32'(Main_full), 32'(0));
        chk("mid_vc_empty",   32'(VC_empty), 32'(2'b11));
        chk("mid_d_empty",    32'(D_empty), 32'(2'b11));
        chk("mid_d_full",     32'(D_full), 32'(2'b00));
        chk("mid_dout",       32'(D_data_out), 32'(0));
        #1;
        reset_L = 1'b1;
        Main_wr      = 1'b1;
        Main_data_in = 6'h15;
        step();
        Main_wr = 1'b0;
        chk("lat_e0_d_empty", 32'(D_empty), 32'(2'b11));
        step();
        chk("lat_e1_d_empty", 32'(D_empty), 32'(2'b11));
        step();
        chk("lat_e2_d_empty", 32'(D_empty), 32'(2'b01));
        chk("lat_e2_dout",    32'(D_data_out), 32'(12'h540));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
